// File: rtl/milano_pkg.sv
// Shared types and helpers for the milano core: LSU operation encodings,
// LSU FSM states and byte-enable templates.
package milano_pkg;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LBU  = 4'd4,
        LSU_LHU  = 4'd5,
        LSU_SB   = 4'd6,
        LSU_SH   = 4'd7,
        LSU_SW   = 4'd8
    } lsu_opt_e;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } lsu_state_e;

    localparam logic [3:0] LSU_BE_B = 4'b0001;
    localparam logic [3:0] LSU_BE_H = 4'b0011;
    localparam logic [3:0] LSU_BE_W = 4'b1111;

    function automatic logic lsu_is_load(lsu_opt_e op);
        return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
               (op == LSU_LBU) || (op == LSU_LHU);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a bus response word and
// sign- or zero-extends it according to the load operation.
module lsu_load_align
    import milano_pkg::*;
(
    input  lsu_opt_e    op_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = rdata_i >> {offset_i, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (op_i)
            LSU_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: data_o = {24'h000000, byte_sel};
            LSU_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: data_o = {16'h0000, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// EX-stage load/store unit: single-beat req/gnt/rvalid bus master with lane
// steering, misalignment detection, optional timeout and load write-back.
module lsu_ctrl
    import milano_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  lsu_opt_e    lsu_operate_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [4:0]  rd_addr_i,
    output logic        lsu_busy_o,
    output logic        rd_wr_en_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_wdata_o,
    output logic        lsu_misaligned_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i
);

    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

    lsu_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:2] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        we_q;
    lsu_opt_e    op_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_lat_q;

    logic        wb_en_q, wb_en_d;
    logic        err_q, err_d;
    logic [4:0]  rd_addr_q;
    logic [31:0] rd_wdata_q;

    logic [31:0] addr;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic        mis_in;
    logic        valid_req;
    logic        accept;
    logic        timeout_hit;
    logic [31:0] align_data;

    assign addr      = operand_a_i + operand_b_i;
    assign valid_req = lsu_req_i && (lsu_operate_i != LSU_NONE);
    // The increment that would make the count reach the limit ends the wait.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) == TO_LIMIT);

    always_comb begin
        be_in    = 4'b0000;
        wdata_in = lsu_wdata_i;
        mis_in   = 1'b0;
        case (lsu_operate_i)
            LSU_LB, LSU_LBU, LSU_SB: begin
                be_in    = LSU_BE_B << addr[1:0];
                wdata_in = {4{lsu_wdata_i[7:0]}};
            end
            LSU_LH, LSU_LHU, LSU_SH: begin
                be_in    = addr[1] ? {LSU_BE_H[1:0], 2'b00} : LSU_BE_H;
                wdata_in = {2{lsu_wdata_i[15:0]}};
                mis_in   = addr[0];
            end
            LSU_LW, LSU_SW: begin
                be_in  = LSU_BE_W;
                mis_in = (addr[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        accept           = 1'b0;
        wb_en_d          = 1'b0;
        err_d            = 1'b0;
        lsu_busy_o       = 1'b0;
        lsu_misaligned_o = 1'b0;
        data_req_o       = 1'b0;
        data_addr_o      = {addr_q, 2'b00};
        data_be_o        = be_q;
        data_wdata_o     = wdata_q;
        data_we_o        = we_q;
        case (state_q)
            IDLE: begin
                data_addr_o  = {addr[31:2], 2'b00};
                data_be_o    = be_in;
                data_wdata_o = wdata_in;
                data_we_o    = lsu_we_i;
                if (valid_req) begin
                    if (mis_in) begin
                        lsu_misaligned_o = 1'b1;
                    end else begin
                        data_req_o = 1'b1;
                        lsu_busy_o = 1'b1;
                        accept     = 1'b1;
                        cnt_d      = 32'd0;
                        state_d    = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                data_req_o = 1'b1;
                lsu_busy_o = 1'b1;
                if (data_gnt_i) begin
                    state_d = WAIT_RVALID;
                    cnt_d   = 32'd0;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WAIT_RVALID: begin
                lsu_busy_o = ~data_rvalid_i;
                if (data_rvalid_i) begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                    wb_en_d = lsu_is_load(op_q) && !data_err_i;
                    err_d   = data_err_i;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    lsu_load_align u_load_align (
        .op_i     (op_q),
        .offset_i (off_q),
        .rdata_i  (data_rdata_i),
        .data_o   (align_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= 32'd0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            op_q       <= LSU_NONE;
            off_q      <= 2'b00;
            rd_lat_q   <= 5'd0;
            wb_en_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_addr_q  <= 5'd0;
            rd_wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_en_q <= wb_en_d;
            err_q   <= err_d;
            // Latch on every accept so completion never depends on the pipeline inputs.
            if (accept) begin
                addr_q   <= addr[31:2];
                be_q     <= be_in;
                wdata_q  <= wdata_in;
                we_q     <= lsu_we_i;
                op_q     <= lsu_operate_i;
                off_q    <= addr[1:0];
                rd_lat_q <= rd_addr_i;
            end
            if (wb_en_d) begin
                rd_addr_q  <= rd_lat_q;
                rd_wdata_q <= align_data;
            end
        end
    end

    assign rd_wr_en_o = wb_en_q;
    assign rd_addr_o  = rd_addr_q;
    assign rd_wdata_o = rd_wdata_q;
    assign lsu_err_o  = err_q;

endmodule
